// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light controller datapath: converter
// FSM states, BCD digit constants and a constant-width helper.
package tlc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Largest legal decimal digit; anything above is rejected.
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  // Reverse double-dabble correction: a digit that reaches 8 after a right
  // shift received a carried-in weight of 8 that is really worth 5.
  localparam logic [3:0] ADJ_THRESH    = 4'd8;
  localparam logic [3:0] ADJ_SUB       = 4'd3;

  // Ceiling log2, usable in constant expressions for counter widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One-digit correction step of reverse double-dabble: after the right shift
// a digit of 8 or more gets 3 subtracted. No borrow can occur because the
// input is at least 8.
module bcd_digit_adj
  import tlc_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Conditional subtract-3 on a single BCD digit.
  always_comb begin
    digit_out = (digit_in >= ADJ_THRESH) ? digit_in - ADJ_SUB : digit_in;
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter for operator-entered timer presets.
// Reverse double-dabble, one bit per clock, start/done handshake. A preset
// containing any digit above 9 completes one edge after start with err set
// and a zero result instead of a value.
module bcd_to_bin_seq
  import tlc_pkg::*;
#(
  parameter int NDIG = 2,
  parameter int BW   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [BW-1:0]     bin_out
);

  localparam int            SW       = 4 * NDIG;
  localparam int            CW       = clog2(SW + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(SW);

  state_e          state_q, state_d;
  logic [SW-1:0]   bcd_sr_q, bcd_sr_d;
  logic [SW-1:0]   bin_sr_q, bin_sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            err_pend_q, err_pend_d;
  logic [BW-1:0]   bin_out_q, bin_out_d;

  logic [NDIG-1:0] digit_bad;
  logic            in_bad;
  logic            accept;
  logic            shift_last;
  logic [2*SW-1:0] shifted;
  logic [SW-1:0]   bcd_adj;

  // {bcd_sr,bin_sr} shifted right by one: bcd_sr LSB moves into bin_sr MSB.
  assign shifted = {1'b0, bcd_sr_q, bin_sr_q[SW-1:1]};

  // Per-digit validity check on the live input and correction of the
  // freshly shifted BCD digits.
  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    assign digit_bad[g] = (bcd_in[4*g +: 4] > BCD_MAX_DIGIT);

    bcd_digit_adj u_adj (
      .digit_in  (shifted[SW + 4*g +: 4]),
      .digit_out (bcd_adj[4*g +: 4])
    );
  end

  assign in_bad     = |digit_bad;
  assign accept     = start && !busy_q;
  assign shift_last = (cnt_q == LAST_CNT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: only valid presets enter SHIFT; SHIFT leaves once all
  // bits have been moved into bin_sr.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !in_bad) state_d = SHIFT;
      SHIFT:   if (shift_last)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values for each state.
  always_comb begin
    bcd_sr_d   = bcd_sr_q;
    bin_sr_d   = bin_sr_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_pend_d = 1'b0;
    bin_out_d  = bin_out_q;
    case (state_q)
      IDLE: begin
        if (err_pend_q) begin
          // Rejected preset: report one edge after capture.
          done_d    = 1'b1;
          err_d     = 1'b1;
          bin_out_d = '0;
          busy_d    = 1'b0;
        end else if (accept) begin
          bcd_sr_d   = bcd_in;
          bin_sr_d   = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          err_d      = 1'b0;
          err_pend_d = in_bad;
        end
      end
      SHIFT: begin
        if (shift_last) begin
          bin_out_d = BW'(bin_sr_q);
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end else begin
          bcd_sr_d = bcd_adj;
          bin_sr_d = shifted[SW-1:0];
          cnt_d    = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_sr_q   <= '0;
      bin_sr_q   <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
      bin_out_q  <= '0;
    end else begin
      bcd_sr_q   <= bcd_sr_d;
      bin_sr_q   <= bin_sr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
      bin_out_q  <= bin_out_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign bin_out = bin_out_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: a 2-digit and a 3-digit instance,
// expected results pushed when a start is accepted and compared on done.
module tb_bcd_to_bin_seq;

  typedef struct {
    int bin;
    bit err;
    int edge_n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start2, start3;
  logic [7:0]  bcd2;
  logic [11:0] bcd3;
  logic        busy2, done2, err2;
  logic [6:0]  bin2;
  logic        busy3, done3, err3;
  logic [9:0]  bin3;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  // Reference model state per instance (index 0: NDIG=2, 1: NDIG=3).
  int   free_edge[2];
  bit   err_m[2];
  int   bin_m[2];
  bit   pend_v[2];
  int   pend_edge[2];
  bit   pend_err[2];
  int   pend_bin[2];

  logic        m_s;
  logic [11:0] m_b;
  int          m_nd, m_v, m_lat;
  bit          m_e;
  exp_t        m_x;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.NDIG(2), .BW(7)) u_dut2 (
    .clk (clk), .rst (rst), .start (start2), .bcd_in (bcd2),
    .busy (busy2), .done (done2), .err (err2), .bin_out (bin2)
  );

  bcd_to_bin_seq #(.NDIG(3), .BW(10)) u_dut3 (
    .clk (clk), .rst (rst), .start (start3), .bcd_in (bcd3),
    .busy (busy3), .done (done3), .err (err3), .bin_out (bin3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Decimal value of a BCD word; any digit above 9 gives err and value 0.
  function automatic void model(input logic [11:0] bcd, input int nd, output int val, output bit e);
    int dg;
    val = 0;
    e   = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      dg = int'(bcd[4*i +: 4]);
      if (dg > 9) e = 1'b1;
      val = val * 10 + dg;
    end
    if (e) val = 0;
  endfunction

  task automatic flush_model();
    sb0.delete();
    sb1.delete();
    for (int d = 0; d < 2; d++) begin
      free_edge[d] = 0;
      err_m[d]     = 1'b0;
      bin_m[d]     = 0;
      pend_v[d]    = 1'b0;
    end
  endtask

  // Model: count edges, retire finished conversions, accept new starts.
  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        free_edge[d] = 0;
        err_m[d]     = 1'b0;
        bin_m[d]     = 0;
        pend_v[d]    = 1'b0;
      end else begin
        if (pend_v[d] && cyc == pend_edge[d]) begin
          err_m[d]  = pend_err[d];
          bin_m[d]  = pend_bin[d];
          pend_v[d] = 1'b0;
        end
        m_s  = (d == 0) ? start2 : start3;
        m_b  = (d == 0) ? {4'h0, bcd2} : bcd3;
        m_nd = (d == 0) ? 2 : 3;
        if (m_s === 1'b1 && cyc >= free_edge[d]) begin
          model(m_b, m_nd, m_v, m_e);
          m_lat        = m_e ? 1 : 4 * m_nd + 1;
          pend_v[d]    = 1'b1;
          pend_edge[d] = cyc + m_lat;
          pend_err[d]  = m_e;
          pend_bin[d]  = m_v;
          err_m[d]     = 1'b0;
          free_edge[d] = cyc + m_lat + 1;
          m_x.bin      = m_v;
          m_x.err      = m_e;
          m_x.edge_n   = cyc + m_lat;
          if (d == 0) sb0.push_back(m_x);
          else        sb1.push_back(m_x);
        end
      end
    end
  end

  task automatic mon(input int d, input logic dn, input logic bs, input logic er,
                     input logic [31:0] bin);
    exp_t e;
    int   sz;
    check($sformatf("busy%0d", d), 32'(bs), 32'(cyc < free_edge[d] - 1));
    check($sformatf("err%0d", d), 32'(er), 32'(err_m[d]));
    check($sformatf("bin_hold%0d", d), bin, 32'(bin_m[d]));
    sz = (d == 0) ? sb0.size() : sb1.size();
    if (dn === 1'b1) begin
      if (sz == 0) begin
        check($sformatf("unexpected_done%0d", d), 32'(dn), 32'd0);
      end else begin
        e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
        check($sformatf("done_bin%0d", d), bin, 32'(e.bin));
        check($sformatf("done_err%0d", d), 32'(er), 32'(e.err));
        check($sformatf("done_edge%0d", d), 32'(cyc), 32'(e.edge_n));
      end
    end else if (sz != 0) begin
      e = (d == 0) ? sb0[0] : sb1[0];
      if (e.edge_n <= cyc) begin
        check($sformatf("missing_done%0d", d), 32'(dn), 32'd1);
        if (d == 0) void'(sb0.pop_front());
        else        void'(sb1.pop_front());
      end
    end
  endtask

  // Compare every output of both instances mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      mon(0, done2, busy2, err2, 32'(bin2));
      mon(1, done3, busy3, err3, 32'(bin3));
    end
  end

  // One-cycle start pulse, then wait until the model says the unit is free.
  task automatic go(input int d, input logic [11:0] b);
    @(posedge clk); #1;
    if (d == 0) begin bcd2 = b[7:0]; start2 = 1'b1; end
    else        begin bcd3 = b;      start3 = 1'b1; end
    @(posedge clk); #1;
    start2 = 1'b0;
    start3 = 1'b0;
    for (int i = 0; i < 40 && cyc < free_edge[d]; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    rst    = 1'b1;
    start2 = 1'b0;
    start3 = 1'b0;
    bcd2   = '0;
    bcd3   = '0;
    flush_model();
    #3;
    check("rst_busy", 32'(busy2), 32'd0);
    check("rst_done", 32'(done2), 32'd0);
    check("rst_err",  32'(err2),  32'd0);
    check("rst_bin",  32'(bin2),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Full-scale, zero, mid-range values.
    go(0, 12'h099);
    go(0, 12'h000);
    go(0, 12'h045);
    // Rejected digit, then a valid preset clears err.
    go(0, 12'h04A);
    go(0, 12'h012);
    go(0, 12'h0F9);
    go(0, 12'h080);

    // Start held high: second start accepted in the done cycle, new input.
    @(posedge clk); #1;
    bcd2   = 8'h37;
    start2 = 1'b1;
    repeat (4) @(posedge clk);
    #1 bcd2 = 8'h25;
    repeat (7) @(posedge clk);
    #1 start2 = 1'b0;
    for (int i = 0; i < 40 && cyc < free_edge[0]; i++) begin
      @(posedge clk); #1;
    end

    // Short random run including occasional invalid low digits.
    for (int n = 0; n < 8; n++) begin
      rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 11))};
      go(0, {4'h0, rb});
    end

    // Asynchronous reset in the middle of an 88 conversion.
    @(posedge clk); #1;
    bcd2   = 8'h88;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    flush_model();
    #1;
    check("midrst_busy", 32'(busy2), 32'd0);
    check("midrst_done", 32'(done2), 32'd0);
    check("midrst_err",  32'(err2),  32'd0);
    check("midrst_bin",  32'(bin2),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) @(posedge clk);

    // Three-digit instance.
    go(1, 12'h999);
    go(1, 12'h9F0);
    go(1, 12'h407);
    go(1, 12'h100);

    repeat (4) @(posedge clk);
    #1;
    check("sb0_drained", 32'(sb0.size()), 32'd0);
    check("sb1_drained", 32'(sb1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
